// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences M-stage loads/stores onto a req/ack data bus,
// stalls the pipeline while an access is outstanding, aligns store lanes,
// extracts/extends load data and flags misaligned accesses.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   MemReadM, MemWriteM      M-stage load / store request
//   ALUResultM               byte address
//   WriteDataM               store data, LSB-justified
//   funct3M                  [1:0] size B/H/W, [2] unsigned load
//   ReadDataM                aligned, extended load data (valid in DONE)
//   StallMem                 freeze F/D/E/M while access outstanding
//   mem_req/we/addr/wdata/wstrb, mem_ack/rdata   data-memory bus
//   mem_err                  one-cycle pulse on misaligned access / timeout
// Optional feature: define DMEM_TIMEOUT_EN to abort a REQ that waits
// TIMEOUT cycles without mem_ack.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [2:0]        funct3M,
    output logic [31:0]       ReadDataM,
    output logic              StallMem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [2:0]        f3_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic        access;
    logic        misaligned;
    logic [1:0]  off;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;
    logic [31:0] rshift;
    logic [31:0] load_ext;
    logic        ack_ok;
    logic        timeout_hit;
    logic        start;

    // Both parameters only document the fixed bus shape in the default build.
    logic unused_params;
    assign unused_params = ^{TIMEOUT[0], DATA_W[0]};

    assign access = MemReadM | MemWriteM;
    assign off    = ALUResultM[1:0];
    assign ack_ok = (state == S_REQ) & mem_ack;
    assign start  = (state == S_IDLE) & access;

    // Request decode: alignment, byte strobes and lane-shifted store data.
    always_comb begin
        misaligned = 1'b0;
        wstrb_n    = 4'b0000;
        unique case (funct3M[1:0])
            2'b00: begin
                misaligned = 1'b0;
                wstrb_n    = 4'b0001 << off;
            end
            2'b01: begin
                misaligned = off[0];
                wstrb_n    = 4'b0011 << off;
            end
            2'b10: begin
                misaligned = |off;
                wstrb_n    = 4'b1111;
            end
            default: begin
                misaligned = 1'b1;
                wstrb_n    = 4'b0000;
            end
        endcase
    end

    assign wdata_n = WriteDataM << {off, 3'b000};

    // Load extraction uses the latched address/funct3, not the live inputs.
    assign rshift = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rshift;
        unique case (f3_q[1:0])
            2'b00:   load_ext = {{24{~f3_q[2] & rshift[7]}}, rshift[7:0]};
            2'b01:   load_ext = {{16{~f3_q[2] & rshift[15]}}, rshift[15:0]};
            default: load_ext = rshift;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt;

    // Counter holds the number of REQ cycles already spent without ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (start) begin
            wait_cnt <= 8'd0;
        end else if ((state == S_REQ) && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == S_REQ) & ~mem_ack & (wait_cnt == TO_LIM);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (access) begin
                    state_n = misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack || timeout_hit) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output logic; bus controls are only live in REQ.
    always_comb begin
        mem_req   = (state == S_REQ);
        mem_we    = (state == S_REQ) & we_q;
        mem_wstrb = (state == S_REQ) ? wstrb_q : 4'b0000;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = wdata_q;
        StallMem  = start | (state == S_REQ);
        ReadDataM = (state == S_DONE) ? rdata_q : 32'd0;
        mem_err   = (state == S_DONE) & err_q;
    end

    // Access registers: latched at the start of an access, load data
    // captured on ack. Error paths leave the read data at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'b0000;
            f3_q    <= 3'b000;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                addr_q  <= ALUResultM;
                we_q    <= MemWriteM & ~misaligned;
                wdata_q <= MemWriteM ? wdata_n : 32'd0;
                wstrb_q <= MemWriteM ? wstrb_n : 4'b0000;
                f3_q    <= funct3M;
                rdata_q <= 32'd0;
                err_q   <= misaligned;
            end
            if (ack_ok) begin
                rdata_q <= load_ext;
                err_q   <= 1'b0;
            end
            if (timeout_hit) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed plus randomized accesses against a
// byte-lane reference model of the data-memory access controller.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic [2:0]  funct3M = 3'd0;
    logic [31:0] ReadDataM;
    logic        StallMem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_err;

    int nvec = 0;
    int nerr = 0;

    dmem_access_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReadM  (MemReadM),
        .MemWriteM (MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .funct3M   (funct3M),
        .ReadDataM (ReadDataM),
        .StallMem  (StallMem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access, bus responds dly cycles after the first REQ cycle.
    task automatic do_acc(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input int dly, input logic [31:0] rdat);
        int nb;
        int off;
        int stalls;
        bit mis;
        logic [3:0] es;
        logic [31:0] ed;
        logic [31:0] er;
        longint v;
        nb  = 1 << f3[1:0];
        off = int'(a % 4);
        mis = (f3[1:0] == 2'b11) || ((a % nb) != 0);
        es  = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (wr && i >= off && i < off + nb) es[i] = 1'b1;
        ed = wd << (8 * off);
        v = 0;
        for (int k = 0; k < nb && k < 4; k++)
            v = v + (longint'((rdat >> (8 * (off + k))) & 32'hFF) << (8 * k));
        if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        er = v[31:0];

        @(negedge clk);
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = a;
        WriteDataM = wd;
        funct3M    = f3;
        #1;
        stalls = 0;
        chk("stall_first", {31'd0, StallMem}, 32'd1);
        chk("req_first", {31'd0, mem_req}, 32'd0);
        if (StallMem) stalls++;
        if (!mis) begin
            for (int d = 0; d <= dly; d++) begin
                @(negedge clk);
                chk("req_hold", {31'd0, mem_req}, 32'd1);
                chk("addr", mem_addr, a & ~32'd3);
                chk("we", {31'd0, mem_we}, {31'd0, wr});
                chk("wstrb", {28'd0, mem_wstrb}, {28'd0, es});
                if (wr) chk("wdata", mem_wdata, ed);
                if (StallMem) stalls++;
                if (d == dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdat;
                end
            end
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        #1;
        chk("done_req", {31'd0, mem_req}, 32'd0);
        chk("done_stall", {31'd0, StallMem}, 32'd0);
        chk("err", {31'd0, mem_err}, {31'd0, mis});
        if (mis) chk("rdata_mis", ReadDataM, 32'd0);
        else if (rd) chk("rdata", ReadDataM, er);
        chk("stall_cycles", stalls, mis ? 1 : dly + 2);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit w;
        logic [2:0] f3;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, StallMem}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_err", {31'd0, mem_err}, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;

        do_acc(1, 0, 32'h100, 32'd0, 3'b010, 0, 32'hDEADBEEF);
        do_acc(0, 1, 32'h203, 32'h000000A5, 3'b000, 1, 32'd0);
        do_acc(1, 0, 32'h102, 32'd0, 3'b001, 2, 32'h80010000);
        do_acc(1, 0, 32'h102, 32'd0, 3'b101, 0, 32'h80010000);
        do_acc(1, 0, 32'h101, 32'd0, 3'b010, 0, 32'd0);
        do_acc(0, 1, 32'h102, 32'h1234ABCD, 3'b001, 0, 32'd0);
        do_acc(1, 0, 32'h303, 32'd0, 3'b000, 1, 32'h80FF_0000);
        do_acc(0, 1, 32'h301, 32'h1234ABCD, 3'b001, 0, 32'd0);

        // Stray ack while idle is ignored.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("stray_req", {31'd0, mem_req}, 32'd0);
        chk("stray_err", {31'd0, mem_err}, 32'd0);

        // Reset while waiting for a slow ack.
        @(negedge clk);
        MemReadM   = 1'b1;
        ALUResultM = 32'h100;
        funct3M    = 3'b010;
        @(negedge clk);
        chk("rst_mid_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        rst      = 1'b1;
        MemReadM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_req_after", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, StallMem}, 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("rst_mid_idle", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_err", {31'd0, mem_err}, 32'd0);

`ifdef DMEM_TIMEOUT_EN
        @(negedge clk);
        MemReadM   = 1'b1;
        ALUResultM = 32'h400;
        funct3M    = 3'b010;
        cnt = 0;
        @(negedge clk);
        while (mem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        #1;
        chk("to_cycles", cnt, 4);
        chk("to_err", {31'd0, mem_err}, 32'd1);
        chk("to_rdata", ReadDataM, 32'd0);
        chk("to_stall", {31'd0, StallMem}, 32'd0);
        MemReadM = 1'b0;
`else
        cnt = 0;
`endif

        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (w) f3[2] = 1'b0;
            do_acc(!w, w, 32'h1000 + $urandom_range(0, 255), $urandom, f3,
                   int'($urandom_range(0, 3)), $urandom);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
